// File: rtl/output_confirm.sv
// output_confirm: processor OUT port with operator acknowledge.
// An OUT request latches a value onto the display register and stalls the core (halt)
// until a debounced rising edge of the confirm button is seen.
// Optional feature: define OUT_AUTOACK_EN to auto-acknowledge after TIMEOUT cycles in WAIT.
module output_confirm #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    input  logic              bot,
    output logic [DATA_W-1:0] out_reg,
    output logic              out_valid,
    output logic              halt,
    output logic              done
);

    // Counter holds 0 .. DEB_CYCLES-1; keep at least one bit.
    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] DebLast = CntW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] out_reg_q;
    logic              out_valid_q;
    logic              halt_q;
    logic              done_q;

    logic              bot_meta_q;
    logic              bot_sync_q;
    logic              deb_level_q;
    logic [CntW-1:0]   deb_cnt_q;
    logic              ack_q;
    logic              timeout_hit;

    // Synchronise the raw button, debounce it and emit a one-cycle pulse on each debounced rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bot_meta_q  <= 1'b0;
            bot_sync_q  <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            ack_q       <= 1'b0;
        end else begin
            bot_meta_q <= bot;
            bot_sync_q <= bot_meta_q;
            ack_q      <= 1'b0;
            if (bot_sync_q != deb_level_q) begin
                if (deb_cnt_q == DebLast) begin
                    deb_level_q <= bot_sync_q;
                    deb_cnt_q   <= '0;
                    // Only a 0->1 change is an acknowledge; a held button never re-fires.
                    ack_q       <= bot_sync_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + CntW'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end
        end
    end

`ifdef OUT_AUTOACK_EN
    localparam int unsigned ToW = $clog2(TIMEOUT);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

    logic [ToW-1:0] to_cnt_q;

    // Count cycles spent in WAIT; held at zero elsewhere so every WAIT entry starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != StWait) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
        end
    end

    assign timeout_hit = (to_cnt_q == ToLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // Request/acknowledge FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_reg_q   <= '0;
            out_valid_q <= 1'b0;
            halt_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (out_req) begin
                        out_reg_q   <= out_data;
                        state_q     <= StWait;
                        halt_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                StWait: begin
                    // Late requests are ignored; the displayed value must not change under the operator.
                    if (ack_q || timeout_hit) begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        halt_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                StDone: begin
                    done_q <= 1'b0;
                    if (out_req) begin
                        out_reg_q   <= out_data;
                        state_q     <= StWait;
                        halt_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    done_q      <= 1'b0;
                    halt_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_reg   = out_reg_q;
    assign out_valid = out_valid_q;
    assign halt      = halt_q;
    assign done      = done_q;

endmodule
